dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data memory between two requesters: port 0, the CPU load/store path, and port 1, the program loader/debug/DMA path.
- Grants are zero-latency: a request is granted in the cycle it is presented, so an uncontended CPU access never stalls. Read data returns one cycle later.
- Round-robin arbitration, with an optional bounded bus lock for port-1 bursts (e.g. image loading).
- Sits between the core's load/store path and the DMEM macro. The CPU stalls while its port is not granted.

Parameters:
- ADDR_W, 32, byte-address width on both ports.
- DATA_W, 32, data width (byte enables are DATA_W/8 bits).
- DEPTH_WORDS, 1024, memory words; word addresses at or above this are out of range.
- LOCK_MAX, 16, maximum consecutive cycles port 1 may hold the lock.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  port 0 access request
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  ADDR_W  port 0 byte address
- m0_wdata  in  DATA_W  port 0 write data
- m0_be  in  DATA_W/8  port 0 byte enables
- m0_gnt  out  1  port 0 request accepted this cycle
- m0_rvalid  out  1  port 0 read response valid
- m0_rdata  out  DATA_W  port 0 read data
- m0_err  out  1  port 0 response is an error (with m0_rvalid)
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1
- m1_lock  in  1  lock request, sampled with an m1 grant
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W-2  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe
- cpu_stall  out  1  equals m0_req & ~m0_gnt

Behaviour:
- Clocking and reset: single clock domain on clk. Reset is synchronous and active-high on rst.
- Reset values:
  - all gnt, rvalid, err, rdata = 0; mem_en = 0
  - FSM in OPEN
  - round-robin pointer = "port 1 granted last", so port 0 wins the first contest
  - lock counter = 0
- Reset mid-operation: any pending read response is dropped, so no rvalid appears in the cycle after reset.
- Request rule: a requester holds req and all request fields stable until its gnt is seen. Exactly one gnt at most per cycle.
- Grant logic (combinational from req, state, pointer):
  - OPEN, one requester: that requester is granted.
  - OPEN, both requesting: the port not granted last is granted; the pointer updates on every grant.
  - LOCKED: only port 1 may be granted; m0_gnt = 0.
- Memory drive:
  - on a grant, mem_en = 1 and mem_we/addr/wdata/be are muxed from the granted port; mem_addr = addr[ADDR_W-1:2]
  - with no grant, mem_en = 0 and the other memory outputs are 0
- Out-of-range or misaligned accesses (word address >= DEPTH_WORDS, or addr[1:0] != 0):
  - still granted, but mem_en stays 0
  - next cycle the port gets rvalid = 1, err = 1, rdata = 0
  - this applies to writes as well, so errors are always reported
- Responses:
  - a normal read granted in cycle N gives rvalid = 1 to its owner in N+1, with rdata = mem_rdata and err = 0
  - writes produce no rvalid
  - rdata is 0 whenever rvalid = 0
  - a registered owner tag plus valid bit records who gets the next response; back-to-back grants every cycle are supported
- FSM:
  - OPEN -> LOCKED when m1 is granted with m1_lock = 1; the lock counter loads 1.
  - LOCKED -> OPEN when m1 is granted with m1_lock = 0, or when the counter reaches LOCK_MAX. On forced release, the pointer is set so port 0 wins the next contest.
  - In LOCKED, the counter increments every cycle, whether or not m1 requests.
- Starvation bound: in OPEN, a pending request is granted within 2 cycles. A port-0 wait is at most LOCK_MAX + 1 cycles.
- Simultaneous events: a grant and a response to different ports in the same cycle are independent and both legal.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - arb_state_t enum (OPEN, LOCKED)
  - port-index constants P_CPU = 0, P_AUX = 1
- One natural sub-module: rr_arbiter2 (2-way round-robin with pointer and mask input).
- FSM, lock counter, range check and response tagging stay in the top module.

Test Plan:
- Port 0 alone reads addr 0x10 (mem word 4 = 0xDEADBEEF) -> m0_gnt in cycle N, mem_addr = 4; m0_rvalid = 1 and m0_rdata = 0xDEADBEEF in N+1; cpu_stall = 0 throughout.
- Both ports issue reads every cycle for 6 cycles after reset -> grant order 0,1,0,1,0,1; each rvalid lands only on its owner, one cycle after its grant.
- Port 1 writes with m1_lock = 1 for 20 cycles while m0_req is held high -> m0_gnt = 0 and cpu_stall = 1 for exactly 16 cycles (LOCK_MAX); forced release; m0 granted on the next cycle.
- Port 0 reads addr 0x1002 and then addr 0x1000 (word 1024, with DEPTH_WORDS = 1024) -> each granted, mem_en = 0, next cycle m0_rvalid = 1, m0_err = 1, m0_rdata = 0.
- Reset asserted the cycle after a port-1 read grant -> no m1_rvalid afterwards; all outputs 0; first contested grant after reset goes to port 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic P_CPU = 1'b0;
  localparam logic P_AUX = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; 'last' names the port granted most recently.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic [1:0] eligible;

  always_comb begin
    eligible = req & mask;
    gnt      = '0;
    gnt_idx  = P_CPU;
    case (eligible)
      2'b01: begin
        gnt     = 2'b01;
        gnt_idx = P_CPU;
      end
      2'b10: begin
        gnt     = 2'b10;
        gnt_idx = P_AUX;
      end
      2'b11: begin
        if (last == P_AUX) begin
          gnt     = 2'b01;
          gnt_idx = P_CPU;
        end else begin
          gnt     = 2'b10;
          gnt_idx = P_AUX;
        end
      end
      default: begin
        gnt     = '0;
        gnt_idx = P_CPU;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Zero-latency round-robin arbiter sharing one synchronous DMEM between the
// CPU load/store port (m0) and the loader/debug/DMA port (m1, with bus lock).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LOCK_MAX    = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_be,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_err,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_be,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_err,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-3:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,

  output logic                  cpu_stall
);

  localparam int                BE_W      = DATA_W / 8;
  localparam int                CNT_W     = $clog2(LOCK_MAX + 1);
  localparam logic [ADDR_W-2:0] DEPTH_LIM = (ADDR_W-1)'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  arb_state_t       state_q, state_nxt;
  logic             last_q, last_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  logic [1:0]       req_v, mask_v, gnt_v;
  logic             gnt_idx, any_gnt;

  logic             sel_we, sel_bad;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]  sel_be;

  logic             rsp_valid_q, rsp_owner_q, rsp_err_q, rsp_live;

  // Reset also gates requests and responses combinationally, so every
  // output reads 0 while rst is high, including a response already in flight.
  always_comb begin
    req_v   = {m1_req, m0_req} & {2{~rst}};
    mask_v  = (state_q == LOCKED) ? 2'b10 : 2'b11;
    any_gnt = |gnt_v;
    m0_gnt  = gnt_v[0];
    m1_gnt  = gnt_v[1];
  end

  rr_arbiter2 u_rr (
    .req     (req_v),
    .mask    (mask_v),
    .last    (last_q),
    .gnt     (gnt_v),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_we    = (gnt_idx == P_AUX) ? m1_we    : m0_we;
    sel_addr  = (gnt_idx == P_AUX) ? m1_addr  : m0_addr;
    sel_wdata = (gnt_idx == P_AUX) ? m1_wdata : m0_wdata;
    sel_be    = (gnt_idx == P_AUX) ? m1_be    : m0_be;
    sel_bad   = (sel_addr[1:0] != 2'b00) ||
                ({1'b0, sel_addr[ADDR_W-1:2]} >= DEPTH_LIM);
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (any_gnt) begin
      mem_en    = ~sel_bad;
      mem_we    = sel_we;
      mem_addr  = sel_addr[ADDR_W-1:2];
      mem_wdata = sel_wdata;
      mem_be    = sel_be;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    last_nxt  = any_gnt ? gnt_idx : last_q;
    case (state_q)
      OPEN: begin
        if (gnt_v[P_AUX] && m1_lock) begin
          state_nxt = LOCKED;
          cnt_nxt   = CNT_ONE;
        end
      end
      LOCKED: begin
        cnt_nxt = cnt_q + CNT_ONE;
        if (cnt_q == CNT_MAX) begin
          // Forced release hands the next contest to the CPU.
          state_nxt = OPEN;
          cnt_nxt   = '0;
          last_nxt  = P_AUX;
        end else if (gnt_v[P_AUX] && !m1_lock) begin
          state_nxt = OPEN;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = OPEN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OPEN;
      last_q  <= P_AUX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      last_q  <= last_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= P_CPU;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= any_gnt & (sel_bad | ~sel_we);
      rsp_owner_q <= gnt_idx;
      rsp_err_q   <= sel_bad;
    end
  end

  always_comb begin
    rsp_live  = rsp_valid_q & ~rst;
    m0_rvalid = rsp_live & (rsp_owner_q == P_CPU);
    m1_rvalid = rsp_live & (rsp_owner_q == P_AUX);
    m0_err    = m0_rvalid & rsp_err_q;
    m1_err    = m1_rvalid & rsp_err_q;
    m0_rdata  = (m0_rvalid && !rsp_err_q) ? mem_rdata : '0;
    m1_rdata  = (m1_rvalid && !rsp_err_q) ? mem_rdata : '0;
    cpu_stall = m0_req & ~m0_gnt;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle grant checks plus a response
// scoreboard drained by an independent monitor.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        mem_en, mem_we, cpu_stall;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
    int          due;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t got;

  logic [31:0] mem [0:1023];

  dmem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH_WORDS (1024),
    .LOCK_MAX    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_be     (m0_be),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_be     (m1_be),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .cpu_stall (cpu_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port memory with byte enables.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:0]];
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a port presents rvalid.
  always @(negedge clk) begin
    #2;
    checks++;
    if ((!m0_rvalid && (m0_rdata !== 32'h0 || m0_err !== 1'b0)) ||
        (!m1_rvalid && (m1_rdata !== 32'h0 || m1_err !== 1'b0))) begin
      errors++;
      $display("FAIL quiet_outputs cyc=%0d: m0 rdata=%h err=%b m1 rdata=%h err=%b, need 0 without rvalid",
               cyc, m0_rdata, m0_err, m1_rdata, m1_err);
    end
    if (m0_rvalid && m1_rvalid) begin
      checks++;
      errors++;
      $display("FAIL dual_rvalid cyc=%0d: both rvalid high, need at most one", cyc);
    end else if (m0_rvalid || m1_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid cyc=%0d: m0_rvalid=%b m1_rvalid=%b, need none",
                 cyc, m0_rvalid, m1_rvalid);
      end else begin
        got = exp_q.pop_front();
        if (m1_rvalid !== got.port || got.due != cyc ||
            (m1_rvalid ? m1_rdata : m0_rdata) !== got.data ||
            (m1_rvalid ? m1_err : m0_err) !== got.err) begin
          errors++;
          $display("FAIL response cyc=%0d: port=%0d data=%h err=%b, need port=%0d data=%h err=%b at cyc %0d",
                   cyc, m1_rvalid, m1_rvalid ? m1_rdata : m0_rdata,
                   m1_rvalid ? m1_err : m0_err, got.port, got.data, got.err, got.due);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_rvalid cyc=%0d: no response, need port=%0d data=%h",
               cyc, exp_q[0].port, exp_q[0].data);
      void'(exp_q.pop_front());
    end
  end

  task automatic drive(input logic r0, input logic we0, input logic [31:0] a0,
                       input logic [31:0] wd0, input logic [3:0] be0,
                       input logic r1, input logic we1, input logic [31:0] a1,
                       input logic [31:0] wd1, input logic [3:0] be1, input logic lk);
    m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = wd0; m0_be = be0;
    m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = wd1; m1_be = be1;
    m1_lock = lk;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
  endtask

  // Checks the combinational grant/memory side just before the rising edge,
  // queues the response owed for the next cycle, then returns at the next negedge.
  task automatic chk(input string name, input logic eg0, input logic eg1,
                     input logic een, input logic [29:0] eaddr,
                     input logic push, input logic pport,
                     input logic [31:0] pdata, input logic perr);
    #4;
    checks++;
    if ({m0_gnt, m1_gnt, mem_en, cpu_stall} !== {eg0, eg1, een, m0_req & ~eg0}) begin
      errors++;
      $display("FAIL %s: gnt0,gnt1,en,stall=%b%b%b%b, need %b%b%b%b",
               name, m0_gnt, m1_gnt, mem_en, cpu_stall, eg0, eg1, een, m0_req & ~eg0);
    end
    checks++;
    if (mem_addr !== eaddr) begin
      errors++;
      $display("FAIL %s_addr: mem_addr=%h, need %h", name, mem_addr, eaddr);
    end
    if (push) exp_q.push_back('{port: pport, data: pdata, err: perr, due: cyc + 1});
    @(negedge clk);
  endtask

  logic [31:0] c_a0 [6];
  logic [31:0] c_a1 [6];
  logic [29:0] c_wd [6];
  logic [31:0] c_dat[6];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[4]    = 32'hDEAD_BEEF;
    mem_rdata = 32'h0;
    c_a0  = '{32'h14, 32'h18, 32'h18, 32'h1C, 32'h1C, 32'h20};
    c_a1  = '{32'h20, 32'h20, 32'h24, 32'h24, 32'h28, 32'h28};
    c_wd  = '{30'd5, 30'd8, 30'd6, 30'd9, 30'd7, 30'd10};
    c_dat = '{32'hA000_0005, 32'hA000_0008, 32'hA000_0006,
              32'hA000_0009, 32'hA000_0007, 32'hA000_000A};

    rst = 1'b1;
    idle();
    chk("reset0", 0, 0, 0, 30'h0, 0, 0, 32'h0, 0);
    chk("reset1", 0, 0, 0, 30'h0, 0, 0, 32'h0, 0);
    rst = 1'b0;

    // Contention straight after reset: port 0 wins first, then alternate.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, c_a0[i], 32'h0, 4'hF, 1, 0, c_a1[i], 32'h0, 4'hF, 0);
      chk($sformatf("contend%0d", i), (i % 2) == 0, (i % 2) == 1, 1, c_wd[i],
          1, (i % 2) == 1, c_dat[i], 0);
    end
    idle();
    chk("idle0", 0, 0, 0, 30'h0, 0, 0, 32'h0, 0);

    drive(1, 0, 32'h10, 32'h0, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    chk("m0_read_0x10", 1, 0, 1, 30'd4, 1, 0, 32'hDEAD_BEEF, 0);
    drive(1, 1, 32'h14, 32'h1122_3344, 4'b0101, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    chk("m0_write_be", 1, 0, 1, 30'd5, 0, 0, 32'h0, 0);
    drive(1, 0, 32'h14, 32'h0, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    chk("m0_readback", 1, 0, 1, 30'd5, 1, 0, 32'hA022_0044, 0);

    // Range and alignment boundaries.
    drive(1, 0, 32'h1002, 32'h0, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    chk("err_1002", 1, 0, 0, 30'h400, 1, 0, 32'h0, 1);
    drive(1, 0, 32'h1000, 32'h0, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    chk("err_1000", 1, 0, 0, 30'h400, 1, 0, 32'h0, 1);
    drive(1, 0, 32'h12, 32'h0, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    chk("err_misalign", 1, 0, 0, 30'd4, 1, 0, 32'h0, 1);
    drive(1, 0, 32'hFFC, 32'h0, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    chk("last_word", 1, 0, 1, 30'h3FF, 1, 0, 32'hA000_03FF, 0);
    drive(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h1000, 32'h1234_5678, 4'hF, 0);
    chk("m1_write_err", 0, 1, 0, 30'h400, 1, 1, 32'h0, 1);
    idle();
    chk("idle1", 0, 0, 0, 30'h0, 0, 0, 32'h0, 0);

    // Port 1 locked burst; CPU stalls exactly 16 cycles then wins.
    drive(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h40, 32'h5A5A_0000, 4'hF, 1);
    chk("lock_start", 0, 1, 1, 30'd16, 0, 0, 32'h0, 0);
    for (int k = 1; k <= 16; k++) begin
      drive(1, 0, 32'h10, 32'h0, 4'hF, 1, 1, 32'h40 + 4 * k, 32'h5A5A_0000 + k, 4'hF, 1);
      chk($sformatf("locked%0d", k), 0, 1, 1, 30'(16 + k), 0, 0, 32'h0, 0);
    end
    drive(1, 0, 32'h10, 32'h0, 4'hF, 1, 1, 32'h84, 32'h5A5A_0011, 4'hF, 1);
    chk("forced_release", 1, 0, 1, 30'd4, 1, 0, 32'hDEAD_BEEF, 0);
    drive(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h84, 32'h5A5A_0011, 4'hF, 1);
    chk("relock", 0, 1, 1, 30'd33, 0, 0, 32'h0, 0);
    drive(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h88, 32'h5A5A_0012, 4'hF, 0);
    chk("unlock", 0, 1, 1, 30'd34, 0, 0, 32'h0, 0);
    drive(1, 0, 32'h40, 32'h0, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    chk("open_after_unlock", 1, 0, 1, 30'd16, 1, 0, 32'h5A5A_0000, 0);

    // Reset right after a locking port-1 read grant.
    drive(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h10, 32'h0, 4'hF, 1);
    chk("pre_reset_m1", 0, 1, 1, 30'd4, 0, 0, 32'h0, 0);
    rst = 1'b1;
    idle();
    chk("mid_reset", 0, 0, 0, 30'h0, 0, 0, 32'h0, 0);
    rst = 1'b0;
    drive(1, 0, 32'h10, 32'h0, 4'hF, 1, 0, 32'h14, 32'h0, 4'hF, 0);
    chk("post_reset_contest", 1, 0, 1, 30'd4, 1, 0, 32'hDEAD_BEEF, 0);
    drive(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h14, 32'h0, 4'hF, 0);
    chk("post_reset_m1", 0, 1, 1, 30'd5, 1, 1, 32'hA022_0044, 0);
    idle();
    chk("idle2", 0, 0, 0, 30'h0, 0, 0, 32'h0, 0);
    chk("idle3", 0, 0, 0, 30'h0, 0, 0, 32'h0, 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, need 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
